// File: rtl/banked_scratchpad_if.sv
// -----------------------------------------------------------------------------
// banked_scratchpad_if
// Request/response bundle between the requesters and the banked scratchpad.
// Each signal has one lane per port.
//   req_valid  [N_PORTS]      request present
//   req_we     [N_PORTS]      1 = write, 0 = read
//   req_addr   [N_PORTS][AW]  global word address
//   req_wdata  [N_PORTS][W]   write data
//   req_ready  [N_PORTS]      request accepted this cycle
//   rsp_valid  [N_PORTS]      read data valid (no backpressure)
//   rsp_data   [N_PORTS][W]   read data
// The master modport is for the requester side. The slave modport is for
// the scratchpad.
// -----------------------------------------------------------------------------
interface banked_scratchpad_if #(
  parameter int N_PORTS = 4,
  parameter int W       = 8,
  parameter int AW      = 14
);
  logic [N_PORTS-1:0]         req_valid;
  logic [N_PORTS-1:0]         req_we;
  logic [N_PORTS-1:0][AW-1:0] req_addr;
  logic [N_PORTS-1:0][W-1:0]  req_wdata;
  logic [N_PORTS-1:0]         req_ready;
  logic [N_PORTS-1:0]         rsp_valid;
  logic [N_PORTS-1:0][W-1:0]  rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/banked_scratchpad.sv
// -----------------------------------------------------------------------------
// banked_scratchpad
// This is a shared scratchpad with several ports. The linear word address
// space is striped across N_BANKS banks, and each bank serves one access per
// cycle. The low address bits select the bank and the upper bits select the
// row. Every bank has its own round-robin arbiter. Reads return exactly one
// cycle after they are accepted, on the port that issued them.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus           banked_scratchpad_if.slave (request/response lanes)
//   conflict_cnt  bank-conflict stall counter
//
// Optional feature: define BANKED_SCRATCHPAD_PERF_EN to build the stall
// counter. conflict_cnt counts the cycles in which at least one valid
// request is not granted, and it saturates at all-ones. When the macro is
// not defined, conflict_cnt is tied to 0.
// -----------------------------------------------------------------------------
module banked_scratchpad #(
  parameter int N_BANKS        = 16,
  parameter int N_PORTS        = 4,
  parameter int W              = 8,
  parameter int DEPTH_PER_BANK = 1024,
  parameter int AW             = $clog2(N_BANKS*DEPTH_PER_BANK)
) (
  input  logic                clk,
  input  logic                rst_n,
  banked_scratchpad_if.slave  bus,
  output logic [31:0]         conflict_cnt
);

  localparam int BW = $clog2(N_BANKS);
  localparam int RW = AW - BW;
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_BANKS-1:0][PW-1:0] rr_ptr;
  logic [N_BANKS-1:0][PW-1:0] grant_port;
  logic [N_BANKS-1:0]         grant_valid;
  logic [N_PORTS-1:0]         ready;
  logic [N_PORTS-1:0][BW-1:0] port_bank;
  logic [N_PORTS-1:0][RW-1:0] port_row;
  logic [N_PORTS-1:0]         rsp_valid_q;
  logic [N_PORTS-1:0][W-1:0]  rsp_data_q;

  logic [W-1:0] mem [N_BANKS][DEPTH_PER_BANK];

  // Split each address into a bank and a row. Consecutive words land in
  // consecutive banks.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      port_bank[p] = bus.req_addr[p][BW-1:0];
      port_row[p]  = bus.req_addr[p][AW-1:BW];
    end
  end

  // Per-bank round-robin arbiter. The search starts at rr_ptr and wraps
  // modulo N_PORTS. The first requester found takes the bank.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch.
    // Without it, a path that skips an assignment infers a latch.
    grant_valid = '0;
    grant_port  = '0;
    idx         = 0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int k = 0; k < N_PORTS; k++) begin
        // NOTE: blocking '=' is used here because idx must hold its new
        // value for the next statement in this same pass.
        idx = int'(rr_ptr[b]) + k;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        if (!grant_valid[b] && bus.req_valid[idx] && port_bank[idx] == BW'(b)) begin
          grant_valid[b] = 1'b1;
          grant_port[b]  = PW'(idx);
        end
      end
    end
  end

  // A port targets exactly one bank, so it is ready when that bank granted it.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      ready[p] = bus.req_valid[p] && grant_valid[port_bank[p]] &&
                 (grant_port[port_bank[p]] == PW'(p));
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  // After a grant, the pointer moves to the port just past the winner. This
  // gives every contender a turn within N_PORTS-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (grant_valid[b]) begin
          // NOTE: state registers use non-blocking '<=' so that every flop
          // samples the values from before the clock edge.
          rr_ptr[b] <= (grant_port[b] == PW'(N_PORTS-1)) ? '0 : grant_port[b] + 1'b1;
        end
      end
    end
  end

  // Bank storage has one write per bank per cycle. It is driven by that
  // bank's winner.
  // NOTE: the memory array has no reset. Its contents are undefined after
  // power-up, and keeping reset off the array lets it map onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (grant_valid[b] && bus.req_we[grant_port[b]]) begin
        mem[b][port_row[grant_port[b]]] <= bus.req_wdata[grant_port[b]];
      end
    end
  end

  // Read responses are registered per port. rsp_data keeps its last value
  // between responses. Reset clears the flags, which drops a read that is
  // still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        rsp_valid_q[p] <= ready[p] && !bus.req_we[p];
        if (ready[p] && !bus.req_we[p]) begin
          rsp_data_q[p] <= mem[port_bank[p]][port_row[p]];
        end
      end
    end
  end

`ifdef BANKED_SCRATCHPAD_PERF_EN
  logic stall;
  assign stall = |(bus.req_valid & ~ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (stall && conflict_cnt != 32'hFFFF_FFFF) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_banked_scratchpad.sv
module tb_banked_scratchpad;
  localparam int NP = 4;
  localparam int AW = 14;
`ifdef BANKED_SCRATCHPAD_PERF_EN
  localparam logic [31:0] EXP_CONFLICT = 32'd3;
`else
  localparam logic [31:0] EXP_CONFLICT = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] conflict_cnt;
  int          errors = 0;
  int          checks = 0;

  logic [7:0] model [1 << AW];
  logic [7:0] exp_q [NP][$];

  banked_scratchpad_if #(.N_PORTS(NP), .W(8), .AW(AW)) bus ();

  banked_scratchpad #(.N_BANKS(16), .N_PORTS(NP), .W(8), .DEPTH_PER_BANK(1024)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic drive(input int p, input logic we, input logic [AW-1:0] addr,
                       input logic [7:0] data);
    bus.req_valid[p] = 1'b1;
    bus.req_we[p]    = we;
    bus.req_addr[p]  = addr;
    bus.req_wdata[p] = data;
  endtask

  task automatic check_ready(input string name, input logic [NP-1:0] exp);
    checks++;
    if (bus.req_ready !== exp) begin
      errors++;
      $display("FAIL %s: req_ready=%b required %b", name, bus.req_ready, exp);
    end
  endtask

  // This runs one clock cycle. It records the accepts into the model and
  // the scoreboard, then checks the responses that appear after the edge.
  task automatic step();
    logic [7:0] e;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (bus.req_ready[p]) begin
        if (bus.req_we[p]) model[bus.req_addr[p]] = bus.req_wdata[p];
        else exp_q[p].push_back(model[bus.req_addr[p]]);
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (bus.rsp_valid[p]) begin
        checks++;
        if (exp_q[p].size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected[%0d]: rsp_valid=1 required 0", p);
        end else begin
          e = exp_q[p].pop_front();
          if (bus.rsp_data[p] !== e) begin
            errors++;
            $display("FAIL rsp_data[%0d]: got %h required %h", p, bus.rsp_data[p], e);
          end
        end
      end else if (exp_q[p].size() != 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing[%0d]: rsp_valid=0 required 1", p);
        exp_q[p].delete();
      end
    end
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
  endtask

  task automatic write_one(input logic [AW-1:0] addr, input logic [7:0] data);
    drive(0, 1'b1, addr, data);
    #1;
    check_ready("preload_ready", 4'b0001);
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_ready("reset_ready", 4'b0000);
    checks++;
    if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== '0 || conflict_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: rsp_valid=%b rsp_data=%h cnt=%0d required all 0",
               bus.rsp_valid, bus.rsp_data, conflict_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 14'h005, 8'hA5);
    #1;
    check_ready("wr_ready", 4'b0001);
    step();
    idle();
    drive(0, 1'b0, 14'h005, 8'h00);
    #1;
    check_ready("rd_ready", 4'b0001);
    step();
    idle();
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL rd_a5: valid=%b data=%h required 0001/a5", bus.rsp_valid, bus.rsp_data[0]);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL rsp_hold: valid=%b data=%h required 0000/a5", bus.rsp_valid, bus.rsp_data[0]);
    end
  endtask

  task automatic test_parallel();
    for (int p = 0; p < NP; p++) drive(p, 1'b1, AW'(p), 8'h10 + 8'(p));
    #1;
    check_ready("par_wr_ready", 4'b1111);
    step();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, AW'(p), 8'h00);
    #1;
    check_ready("par_rd_ready", 4'b1111);
    step();
    idle();
    checks++;
    if (bus.rsp_valid !== 4'b1111) begin
      errors++;
      $display("FAIL par_rsp_valid: got %b required 1111", bus.rsp_valid);
    end
  endtask

  task automatic test_conflict();
    logic [NP-1:0] pending;
    write_one(14'd18, 8'h3C);
    write_one(14'd34, 8'h5A);
    write_one(14'd50, 8'hC3);
    write_one(14'd16, 8'h77);
    apply_reset();
    drive(0, 1'b0, 14'd2, 8'h00);
    drive(1, 1'b0, 14'd18, 8'h00);
    drive(2, 1'b0, 14'd34, 8'h00);
    drive(3, 1'b0, 14'd50, 8'h00);
    pending = 4'b1111;
    for (int k = 0; k < NP; k++) begin
      #1;
      check_ready($sformatf("conflict_grant%0d", k), 4'b0001 << k);
      step();
      pending[k] = 1'b0;
      bus.req_valid = pending;
    end
    idle();
    checks++;
    if (conflict_cnt !== EXP_CONFLICT) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d required %0d", conflict_cnt, EXP_CONFLICT);
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    drive(1, 1'b0, 14'd0, 8'h00);
    drive(3, 1'b0, 14'd16, 8'h00);
    for (int k = 0; k < 6; k++) begin
      #1;
      check_ready($sformatf("alt_grant%0d", k), (k % 2 == 0) ? 4'b0010 : 4'b1000);
      step();
    end
    idle();
    step();
  endtask

  task automatic test_reset_inflight();
    // Port 1 takes bank 0, which leaves that bank's pointer at 2.
    drive(1, 1'b0, 14'd0, 8'h00);
    #1;
    check_ready("inflight_accept", 4'b0010);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL inflight_dropped: rsp_valid=%b required 0000", bus.rsp_valid);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_valid: rsp_valid=%b required 0000", bus.rsp_valid);
    end
    // With the pointer back at 0, port 0 must beat port 3 for bank 0.
    drive(0, 1'b0, 14'd0, 8'h00);
    drive(3, 1'b0, 14'd16, 8'h00);
    #1;
    check_ready("post_reset_rr", 4'b0001);
    step();
    idle();
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_parallel();
    test_conflict();
    test_alternate();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/banked_scratchpad.md
# banked_scratchpad

Multi-port, bank-interleaved scratchpad that generalises the flat per-bank memory array into a shared memory. N_PORTS requesters see one linear address space striped across N_BANKS single-access banks, with per-bank round-robin arbitration, valid/ready request handshake and fixed-latency read responses routed back to the issuing port. It sits between the matrix-multiply datapath engines (operand fetch, result writeback) and on-chip block RAM.

## Interface
- N_BANKS, 16: bank count; power of two, ≥2.
- N_PORTS, 4: requester count, ≥1.
- W, 8: data width in bits.
- DEPTH_PER_BANK, 1024: words per bank; power of two.
- AW, $clog2(N_BANKS*DEPTH_PER_BANK): derived global word-address width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [N_PORTS]  request present.
- req_we  in  [N_PORTS]  1 = write, 0 = read.
- req_addr  in  [N_PORTS][AW]  global word address.
- req_wdata  in  [N_PORTS][W]  write data.
- req_ready  out  [N_PORTS]  request accepted this cycle.
- rsp_valid  out  [N_PORTS]  read data valid.
- rsp_data  out  [N_PORTS][W]  read data.
- conflict_cnt  out  32  bank-conflict stall counter (see Configuration).

## Operation
- Bank select = req_addr[$clog2(N_BANKS)-1:0]; row = remaining upper bits. Consecutive addresses land in consecutive banks.
- Each bank performs at most one access per cycle. Per bank, a round-robin arbiter grants one of the ports whose valid request targets that bank.
- Arbiter: per-bank pointer rr_ptr, reset 0. Grant goes to the first requesting port at index ≥ rr_ptr, wrapping mod N_PORTS. On any grant, rr_ptr ← granted+1 mod N_PORTS; with no grant, rr_ptr holds.
- req_ready[p] = 1 only when port p is valid and granted. It is combinational from req_valid/req_addr. Ungranted ports hold request stable until accepted.
- Write: on accept, mem[bank][row] ← req_wdata at that edge. No response is produced.
- Read: on accept, the bank reads; rsp_valid[p] asserts exactly one cycle later with the data. Responses have no backpressure.
- Read and write to the same address in the same cycle cannot occur, because a bank serves one port per cycle.
- A read of a row written in an earlier cycle returns the new data.
- Reset clears every rr_ptr, rsp_valid and the counter. Memory contents are not reset.
- Reset asserted while a read is in flight drops that response. rsp_valid stays 0 until new requests are accepted after rst_n deasserts.

## Timing
- Reset values: req_ready 0 (no valid inputs), rsp_valid 0, rsp_data 0, conflict_cnt 0.
- Accept at edge t → rsp_valid/rsp_data valid during cycle t+1, registered.
- Throughput: up to min(N_PORTS, N_BANKS) accepts per cycle when banks are distinct.
- Conflicting port stalls ≥1 cycle. The worst-case wait is N_PORTS-1 cycles under continuous contention; no starvation.
- rsp_data holds its last value when rsp_valid = 0.

## Configuration
- BANKED_SCRATCHPAD_PERF_EN defined: conflict_cnt increments by 1 each cycle in which at least one valid request is not granted. It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined: the counter logic is absent and conflict_cnt is tied to 0.

## Test plan
- Reset then idle: all outputs 0.
- Port 0 writes addr 0x005 = 0xA5, then reads 0x005 → rsp_valid[0] one cycle after accept, rsp_data[0] = 0xA5.
- Ports 0–3 read addrs 0,1,2,3 (distinct banks) in the same cycle → all four req_ready high; all four responses next cycle.
- Ports 0–3 hold reads to bank 2 (addrs 2,18,34,50) → grants in order 0,1,2,3, one per cycle. conflict_cnt = 3 with PERF_EN, 0 without.
- Ports 1 and 3 continuously contend for bank 0 → grants alternate 1,3,1,3; neither waits >1 cycle.
- Read accepted, rst_n pulsed low next cycle → no rsp_valid; rr_ptr back to 0 (port 0 wins next conflict).
